// File: rtl/matrix_scalar_multiply.sv
// Scales a ROWS x COLS signed matrix by a signed scalar, one element per clock in
// row-major order, saturating each product to the element width.
module matrix_scalar_multiply #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int WIDTH      = 16,
    parameter int MULT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [WIDTH-1:0]      matrix_in  [ROWS][COLS],
    input  logic signed [MULT_WIDTH-1:0] multiplier,
    output logic signed [WIDTH-1:0]      matrix_out [ROWS][COLS],
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [1:0]                   state_dbg
);

    // Handshake: start is sampled only in IDLE; done pulses for the single DONE
    // cycle; busy covers COMPUTE and DONE.
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

    localparam int PW    = WIDTH + MULT_WIDTH;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(MULT_WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(MULT_WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                         state_q, state_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [COL_W-1:0]               col_q, col_d;
    logic signed [WIDTH-1:0]        lat_q [ROWS][COLS];
    logic signed [WIDTH-1:0]        lat_d [ROWS][COLS];
    logic signed [MULT_WIDTH-1:0]   mult_q, mult_d;
    logic signed [WIDTH-1:0]        out_q [ROWS][COLS];
    logic signed [WIDTH-1:0]        out_d [ROWS][COLS];
    logic                           ovf_q, ovf_d;

    logic signed [PW-1:0]           prod;
    logic signed [WIDTH-1:0]        sat_val;
    logic                           sat_hit;

    assign prod = PW'(lat_q[row_q][col_q]) * PW'(mult_q);

    always_comb begin
        sat_hit = 1'b1;
        sat_val = prod[WIDTH-1:0];
        if (prod > SAT_MAX) begin
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (prod < SAT_MIN) begin
            sat_val = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lat_d   = lat_q;
        mult_d  = mult_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lat_d   = matrix_in;
                    mult_d  = multiplier;
                    ovf_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                out_d[row_q][col_q] = sat_val;
                if (sat_hit) begin
                    ovf_d = 1'b1;
                end
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mult_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    lat_q[i][j] <= '0;
                    out_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mult_q  <= mult_d;
            ovf_q   <= ovf_d;
            lat_q   <= lat_d;
            out_q   <= out_d;
        end
    end

    assign matrix_out = out_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign overflow   = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_matrix_scalar_multiply.sv
// Scoreboard bench for matrix_scalar_multiply: a 3x3 and a 2x4 instance checked
// against a saturating-multiply reference model.
module tb_matrix_scalar_multiply;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic signed [15:0] matrix_in [3][3];
    logic signed [15:0] matrix_out [3][3];
    logic signed [15:0] min2 [2][4];
    logic signed [15:0] mout2 [2][4];
    logic signed [7:0]  multiplier = '0;
    logic signed [7:0]  mult2 = '0;
    logic busy, done, overflow, busy2, done2, ovf2;
    logic [1:0] st, st2;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];
    logic         exp_ovf_q[$];
    logic         exp2_ovf_q[$];
    int           exp_done_q[$];
    int           exp2_done_q[$];

    logic signed [15:0] stim_m [3][3];
    logic signed [15:0] last_exp [3][3];
    logic signed [15:0] stim2 [2][4];
    logic signed [15:0] last2 [2][4];
    logic signed [15:0] e_mon, e_mon2;

    matrix_scalar_multiply u_dut (
        .clk(clk), .reset(reset), .start(start), .matrix_in(matrix_in),
        .multiplier(multiplier), .matrix_out(matrix_out), .busy(busy),
        .done(done), .overflow(overflow), .state_dbg(st)
    );

    matrix_scalar_multiply #(.ROWS(2), .COLS(4)) u_dut24 (
        .clk(clk), .reset(reset), .start(start2), .matrix_in(min2),
        .multiplier(mult2), .matrix_out(mout2), .busy(busy2),
        .done(done2), .overflow(ovf2), .state_dbg(st2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat_mul(input longint a, input longint m);
        longint p = a * m;
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: each done pulse pops one expected operation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_done_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done at cycle %0d, none expected", cyc);
            end else begin
                check("done_cycle", cyc, exp_done_q.pop_front());
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        e_mon = exp_q.pop_front();
                        check($sformatf("elem[%0d][%0d]", i, j), matrix_out[i][j], e_mon);
                    end
                end
                check("overflow", overflow, exp_ovf_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (exp2_done_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done2: done at cycle %0d, none expected", cyc);
            end else begin
                check("done2_cycle", cyc, exp2_done_q.pop_front());
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        e_mon2 = exp2_q.pop_front();
                        check($sformatf("elem2[%0d][%0d]", i, j), mout2[i][j], e_mon2);
                    end
                end
                check("overflow2", ovf2, exp2_ovf_q.pop_front());
            end
        end
    end

    task automatic issue(input int k);
        bit ov = 1'b0;
        longint p;
        @(negedge clk);
        matrix_in  = stim_m;
        multiplier = 8'(k);
        start      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p = sat_mul(stim_m[i][j], k);
                if (p != longint'(stim_m[i][j]) * k) ov = 1'b1;
                last_exp[i][j] = 16'(p);
                exp_q.push_back(16'(p));
            end
        end
        exp_ovf_q.push_back(ov);
        exp_done_q.push_back(cyc + 10);
        @(negedge clk);
        start = 1'b0;
        multiplier = 8'($urandom);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                matrix_in[i][j] = 16'($urandom);
    endtask

    task automatic issue2(input int k);
        bit ov = 1'b0;
        longint p;
        @(negedge clk);
        min2   = stim2;
        mult2  = 8'(k);
        start2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                p = sat_mul(stim2[i][j], k);
                if (p != longint'(stim2[i][j]) * k) ov = 1'b1;
                last2[i][j] = 16'(p);
                exp2_q.push_back(16'(p));
            end
        end
        exp2_ovf_q.push_back(ov);
        exp2_done_q.push_back(cyc + 9);
        @(negedge clk);
        start2 = 1'b0;
        mult2  = 8'($urandom);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                min2[i][j] = 16'($urandom);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: busy still 1 after %0d cycles, required 0", c);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("hold[%0d][%0d]", i, j), matrix_out[i][j], last_exp[i][j]);
    endtask

    task automatic wait_idle2();
        int c = 0;
        while (busy2 && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (busy2) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout2: busy2 still 1 after %0d cycles, required 0", c);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("hold2[%0d][%0d]", i, j), mout2[i][j], last2[i][j]);
    endtask

    task automatic rand_small();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                stim_m[i][j] = 16'($urandom_range(0, 400) - 200);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("%s_out[%0d][%0d]", tag, i, j), matrix_out[i][j], 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_state"}, st, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                matrix_in[i][j] = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                min2[i][j] = '0;

        #1;
        check_all_zero("rst");
        check("rst_busy2", busy2, 0);
        check("rst_state2", st2, 0);
        #20;
        @(negedge clk);
        reset = 1'b1;

        // Basic ascending matrix.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                stim_m[i][j] = 16'((i * 3 + j + 1) * 10);
        issue(2);
        wait_idle();

        // Negative multiplier, mixed signs.
        stim_m = '{'{-16'sd10, -16'sd20, -16'sd30}, '{16'sd40, -16'sd50, 16'sd60},
                   '{-16'sd70, 16'sd80, -16'sd90}};
        issue(-3);
        wait_idle();

        // Saturation at both rails, then positive-rail saturation of -32768 * -1.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                stim_m[i][j] = 16'sd1;
        stim_m[0][0] = 16'sd20000;
        stim_m[0][1] = -16'sd20000;
        stim_m[2][2] = -16'sd32768;
        issue(2);
        wait_idle();
        issue(-1);
        wait_idle();

        // Start re-pulsed mid-run and in DONE with new operands: must be ignored.
        rand_small();
        issue(7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 9) check($sformatf("busy_hold_c%0d", c), busy, 1);
            start = (c == 3 || c == 9);
            if (start)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        matrix_in[i][j] = 16'($urandom);
        end
        start = 1'b0;
        wait_idle();

        // Randomized operations, alternating small and full-range operands.
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) rand_small();
            else
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        stim_m[i][j] = 16'($urandom);
            issue(int'($urandom_range(0, 255)) - 128);
            wait_idle();
        end

        // Reset in the middle of a saturating run.
        rand_small();
        stim_m[0][0] = 16'sd30000;
        issue(4);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        exp_ovf_q.delete();
        exp_done_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rand_small();
        issue(0);
        wait_idle();

        // 2x4 instance.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                stim2[i][j] = 16'(i * 4 + j + 1);
        issue2(5);
        wait_idle2();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 4; j++)
                    stim2[i][j] = 16'($urandom);
            issue2(int'($urandom_range(0, 255)) - 128);
            wait_idle2();
        end

        repeat (5) @(negedge clk);
        check("sb_drain", exp_done_q.size(), 0);
        check("sb_drain2", exp2_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_scalar_multiply.md
MATRIX_SCALAR_MULTIPLY -- requirements
Module: matrix_scalar_multiply

Interface
REQ-001 The module SHALL have parameter ROWS, default 3, matrix row count.
REQ-002 The module SHALL have parameter COLS, default 3, matrix column count.
REQ-003 The module SHALL have parameter WIDTH, default 16, signed element width.
REQ-004 The module SHALL have parameter MULT_WIDTH, default 8, signed multiplier width.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit, operation request.
REQ-008 The module SHALL have port matrix_in, input, signed WIDTH x [ROWS][COLS], operand matrix.
REQ-009 The module SHALL have port multiplier, input, signed MULT_WIDTH, scale factor.
REQ-010 The module SHALL have port matrix_out, output, signed WIDTH x [ROWS][COLS], registered result matrix.
REQ-011 The module SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-012 The module SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-013 The module SHALL have port overflow, output, 1 bit, sticky saturation flag for the current or last operation.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COMPUTE, DONE.
REQ-015 In IDLE, when start=1 at a rising edge, the module SHALL latch matrix_in and multiplier, clear overflow, reset the row/col indices to 0, and enter COMPUTE.
REQ-016 In COMPUTE, the module SHALL write exactly one element per clock in row-major order (row 0 col 0 first, col index fastest).
REQ-017 Each element SHALL be computed as latched_in[i][j] * latched_multiplier, using a full-precision signed product of WIDTH+MULT_WIDTH bits.
REQ-018 Products above 2^(WIDTH-1)-1 SHALL saturate to that value, and products below -2^(WIDTH-1) SHALL saturate to that value; no wrap-around is permitted.
REQ-019 Any saturation SHALL set overflow to 1 at the same edge the element is written, and overflow SHALL hold until the next accepted start or reset.
REQ-020 The edge that writes element [ROWS-1][COLS-1] SHALL move the FSM to DONE.
REQ-021 The index counters SHALL wrap col to 0 and increment row when col reaches COLS-1.
REQ-022 done SHALL be 1 only while in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-023 Latency: when start is sampled at edge N, done SHALL be high between edge N+ROWS*COLS and edge N+ROWS*COLS+1.
REQ-024 busy SHALL be 1 in COMPUTE and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored in COMPUTE and DONE; the operation in progress continues unchanged.
REQ-026 Changes to matrix_in or multiplier after the start edge SHALL NOT affect the running operation.
REQ-027 matrix_out elements not yet rewritten during an operation SHALL hold their prior values.
REQ-028 After done, all of matrix_out SHALL hold its values until the next operation rewrites them.
REQ-029 A start held high continuously SHALL launch a new operation from each IDLE cycle it is sampled in.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, all matrix_out elements to 0, busy=0, done=0, overflow=0, and the indices and latched operands to 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-032 After reset deasserts, the first start sampled SHALL begin a fresh operation.

Verification
REQ-033 The bench SHALL cover this scenario: 3x3 input {10..90 step 10}, multiplier=2, pulse start -> matrix_out={20,40,60;80,100,120;140,160,180}, done pulse 9 edges after start, overflow=0.
REQ-034 The bench SHALL cover this scenario: input {-10,-20,-30;40,-50,60;-70,80,-90}, multiplier=-3 -> {30,60,90;-120,150,-180;210,-240,270}, overflow=0.
REQ-035 The bench SHALL cover this scenario: input with [0][0]=20000, [0][1]=-20000, [2][2]=-32768, rest 1, multiplier=2 for the first two elements and then a separate run with multiplier=-1 -> 32767, -32768, 2 (first run) and 32767 at [2][2] (second run); overflow=1 after each run.
REQ-036 The bench SHALL cover this scenario: start pulsed again at cycles 3 and 9 of a run with a changed matrix_in -> the results match the original operands, only one done pulse occurs, and busy stays high.
REQ-037 The bench SHALL cover this scenario: reset driven low at cycle 4 of a run -> outputs are 0 immediately, no done pulse, and a following start with multiplier=0 gives an all-zero matrix_out and done after 9 edges.
REQ-038 The bench SHALL cover this scenario: a 2x4 parameterization with input 1..8 and multiplier=5 -> {5,10,15,20;25,30,35,40}, done 8 edges after start.
